vx_tcu_drl_exp_align: RTL and testbench

Pipelined exponent-alignment stage directly downstream of the per-lane exponent add/bias logic in the TCU dot-product datapath. It collects the biased product exponents of N lanes and finds their maximum. It then produces per-lane right-shift amounts for mantissa alignment before the adder tree. For FP8/BF8 it also produces the intra-lane sub-product shift from the signed exponent difference.

---
 rtl/vx_tcu_drl_exp_align.sv | 130 +++++++++++++
 tb/tb_vx_tcu_drl_exp_align.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tcu_drl_exp_align.sv
// vx_tcu_drl_exp_align: two-stage elastic max-exponent and mantissa-alignment shift stage.
// Optional VX_TCU_DRL_ALIGN_STICKY_EN adds shift_sat, flagging lanes shifted completely out.
module vx_tcu_drl_exp_align #(
  parameter int N       = 8,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [2:0]           fmt_s,
  input  logic [N-1:0]         lane_mask,
  input  logic [N*8-1:0]       raw_exp_y,
  input  logic [N-1:0]         exp_low_larger,
  input  logic [N*7-1:0]       raw_exp_diff,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [2:0]           fmt_out,
  output logic [7:0]           max_exp,
  output logic [N*SHIFT_W-1:0] shift_amt,
  output logic [N*SHIFT_W-1:0] sub_shift,
  output logic [N-1:0]         sub_sel,
  output logic [TAG_W-1:0]     tag_out
`ifdef VX_TCU_DRL_ALIGN_STICKY_EN
  , output logic [N-1:0]       shift_sat
`endif
);
  localparam int SMAX = 2**SHIFT_W - 1;
  logic                 s1_valid_q, s2_valid_q, adv2, fmt_ok, fp8;
  logic [7:0]           max_d, s1_max_q, s2_max_q;
  logic [N*8-1:0]       s1_exp_q, dist_c;
  logic [N-1:0]         s1_mask_q, s1_sel_q, sel_d, s2_sel_q;
  logic [N*7-1:0]       s1_diff_q;
  logic [2:0]           s1_fmt_q, s2_fmt_q;
  logic [TAG_W-1:0]     s1_tag_q, s2_tag_q;
  logic [N*SHIFT_W-1:0] shift_d, s2_shift_q, sub_d, s2_sub_q;
  assign adv2     = !s2_valid_q || ready_out;
  assign ready_in = !s1_valid_q || adv2;
  assign fmt_ok   = s1_fmt_q >= 3'd1 && s1_fmt_q <= 3'd4;
  assign fp8      = s1_fmt_q == 3'd3 || s1_fmt_q == 3'd4;
  // Heap-ordered comparator tree: leaves at N-1..2N-2, root at 0; masked lanes enter as 0.
  always_comb begin : max_tree
    logic [7:0] t [2*N-1];
    t = '{default: '0};
    for (int i = 0; i < N; i++) t[N-1+i] = lane_mask[i] ? 8'd0 : raw_exp_y[i*8 +: 8];
    for (int i = N-2; i >= 0; i--) t[i] = t[2*i+1] > t[2*i+2] ? t[2*i+1] : t[2*i+2];
    max_d = t[0];
  end
  always_comb begin : align
    logic [6:0] a;
    a       = '0;
    dist_c  = '0;
    shift_d = '0;
    sub_d   = '0;
    for (int i = 0; i < N; i++) begin
      dist_c[i*8 +: 8] = s1_max_q - s1_exp_q[i*8 +: 8];
      a = s1_diff_q[i*7+6] ? -s1_diff_q[i*7 +: 7] : s1_diff_q[i*7 +: 7];
      shift_d[i*SHIFT_W +: SHIFT_W] = (s1_mask_q[i] || int'(dist_c[i*8 +: 8]) > SMAX) ? '1 : SHIFT_W'(dist_c[i*8 +: 8]);
      sub_d[i*SHIFT_W +: SHIFT_W] = int'(a) > SMAX ? '1 : SHIFT_W'(a);
    end
    if (!fmt_ok) shift_d = '0;
    if (!fp8) sub_d = '0;
    sel_d = fp8 ? s1_sel_q : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_max_q   <= '0;
      s1_exp_q   <= '0;
      s1_mask_q  <= '0;
      s1_diff_q  <= '0;
      s1_sel_q   <= '0;
      s1_fmt_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (ready_in) s1_valid_q <= valid_in;
      if (valid_in && ready_in) begin
        s1_max_q  <= max_d;
        s1_exp_q  <= raw_exp_y;
        s1_mask_q <= lane_mask;
        s1_diff_q <= raw_exp_diff;
        s1_sel_q  <= exp_low_larger;
        s1_fmt_q  <= fmt_s;
        s1_tag_q  <= tag_in;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_fmt_q   <= '0;
      s2_max_q   <= '0;
      s2_shift_q <= '0;
      s2_sub_q   <= '0;
      s2_sel_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        s2_fmt_q   <= s1_fmt_q;
        s2_max_q   <= fmt_ok ? s1_max_q : 8'd0;
        s2_shift_q <= shift_d;
        s2_sub_q   <= sub_d;
        s2_sel_q   <= sel_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end
`ifdef VX_TCU_DRL_ALIGN_STICKY_EN
  logic [N-1:0] sat_d, s2_sat_q;
  always_comb begin
    sat_d = '0;
    for (int i = 0; i < N; i++) sat_d[i] = fmt_ok && !s1_mask_q[i] && int'(dist_c[i*8 +: 8]) > SMAX;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s2_sat_q <= '0;
    else if (adv2 && s1_valid_q) s2_sat_q <= sat_d;
  end
  assign shift_sat = s2_sat_q;
`endif
  assign valid_out = s2_valid_q;
  assign fmt_out   = s2_fmt_q;
  assign max_exp   = s2_max_q;
  assign shift_amt = s2_shift_q;
  assign sub_shift = s2_sub_q;
  assign sub_sel   = s2_sel_q;
  assign tag_out   = s2_tag_q;
endmodule

// File: tb/tb_vx_tcu_drl_exp_align.sv
// tb_vx_tcu_drl_exp_align: directed and randomized checks of the exponent-align stage against an arithmetic reference model.
module tb_vx_tcu_drl_exp_align;
  localparam int N    = 8;
  localparam int SW   = 5;
  localparam int TW   = 8;
  localparam int SMAX = 2**SW - 1;
  typedef struct packed {
    logic [2:0]    fmt;
    logic [N-1:0]  mask;
    logic [N*8-1:0] exp;
    logic [N-1:0]  sel;
    logic [N*7-1:0] diff;
    logic [TW-1:0] tag;
  } beat_t;
  typedef struct packed {
    logic [2:0]     fmt;
    logic [7:0]     mx;
    logic [N*SW-1:0] sh;
    logic [N*SW-1:0] sub;
    logic [N-1:0]   sel;
    logic [TW-1:0]  tag;
  } out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in, ready_in, valid_out, ready_out;
  logic [2:0] fmt_s, fmt_out;
  logic [N-1:0] lane_mask, exp_low_larger, sub_sel;
  logic [N*8-1:0] raw_exp_y;
  logic [N*7-1:0] raw_exp_diff;
  logic [TW-1:0] tag_in, tag_out;
  logic [7:0] max_exp;
  logic [N*SW-1:0] shift_amt, sub_shift;
  int vecs = 0;
  int errs = 0;
  vx_tcu_drl_exp_align #(.N(N), .SHIFT_W(SW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .fmt_s(fmt_s), .lane_mask(lane_mask), .raw_exp_y(raw_exp_y),
    .exp_low_larger(exp_low_larger), .raw_exp_diff(raw_exp_diff), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .fmt_out(fmt_out), .max_exp(max_exp),
    .shift_amt(shift_amt), .sub_shift(sub_shift), .sub_sel(sub_sel), .tag_out(tag_out)
  );
  always #5 clk = ~clk;
  // Reference: max over unmasked lanes, distances clamped at SMAX, |diff| only for FP8/BF8.
  function automatic out_t model(beat_t b);
    out_t o;
    int mx, d, a;
    bit ok, f8;
    o = '0;
    ok = b.fmt >= 1 && b.fmt <= 4;
    f8 = b.fmt == 3 || b.fmt == 4;
    o.fmt = b.fmt;
    o.tag = b.tag;
    mx = 0;
    for (int i = 0; i < N; i++)
      if (!b.mask[i] && int'(b.exp[i*8 +: 8]) > mx) mx = int'(b.exp[i*8 +: 8]);
    if (!ok) return o;
    o.mx = 8'(mx);
    for (int i = 0; i < N; i++) begin
      d = mx - int'(b.exp[i*8 +: 8]);
      o.sh[i*SW +: SW] = SW'(b.mask[i] ? SMAX : (d > SMAX ? SMAX : d));
      a = $signed(b.diff[i*7 +: 7]);
      if (a < 0) a = -a;
      o.sub[i*SW +: SW] = f8 ? SW'(a > SMAX ? SMAX : a) : '0;
      o.sel[i] = f8 & b.sel[i];
    end
    return o;
  endfunction
  function automatic out_t dut_o();
    return {fmt_out, max_exp, shift_amt, sub_shift, sub_sel, tag_out};
  endfunction
  function automatic beat_t rand_beat(int tag);
    beat_t b;
    int base;
    b.fmt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
    b.mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    base   = int'($urandom_range(40, 255));
    for (int i = 0; i < N; i++) begin
      b.exp[i*8 +: 8]  = 8'(base - int'($urandom_range(0, 40)));
      b.diff[i*7 +: 7] = 7'($urandom);
    end
    b.sel = N'($urandom);
    b.tag = TW'(tag);
    return b;
  endfunction
  task automatic drive(beat_t b, bit v);
    valid_in       = v;
    fmt_s          = b.fmt;
    lane_mask      = b.mask;
    raw_exp_y      = b.exp;
    exp_low_larger = b.sel;
    raw_exp_diff   = b.diff;
    tag_in         = b.tag;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    vecs++; if (dut_o() !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", dut_o()); end
    vecs++; if (ready_in !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready_in); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL post_reset_valid: got %b want 0", valid_out); end
  endtask
  task automatic test_fp16;
    beat_t b;
    int e[N] = '{100, 98, 105, 105, 90, 60, 105, 101};
    int s[N] = '{5, 7, 0, 0, 15, 31, 0, 4};
    logic [N*SW-1:0] es;
    b = '0;
    b.fmt = 3'd1;
    b.tag = 8'h11;
    b.sel = '1;
    for (int i = 0; i < N; i++) begin
      b.exp[i*8 +: 8]  = 8'(e[i]);
      b.diff[i*7 +: 7] = 7'($urandom);
      es[i*SW +: SW]   = SW'(s[i]);
    end
    ready_out = 1'b1;
    drive(b, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL fp16_early: valid_out got %b want 0", valid_out); end
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL fp16_latency: valid_out got %b want 1", valid_out); end
    vecs++; if (max_exp !== 8'd105) begin errs++; $display("FAIL fp16_max: got %0d want 105", max_exp); end
    vecs++; if (shift_amt !== es) begin errs++; $display("FAIL fp16_shift: got %h want %h", shift_amt, es); end
    vecs++; if ({sub_shift, sub_sel} !== '0) begin errs++; $display("FAIL fp16_sub: got %h/%h want 0", sub_shift, sub_sel); end
    vecs++; if (dut_o() !== model(b)) begin errs++; $display("FAIL fp16_model: got %h want %h", dut_o(), model(b)); end
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL fp16_nodup: valid_out got %b want 0", valid_out); end
  endtask
  task automatic test_fp8;
    beat_t b;
    logic [N*SW-1:0] es;
    b = '0;
    b.fmt = 3'd3;
    b.tag = 8'h22;
    b.sel = 8'b0010_0001;
    for (int i = 0; i < N; i++) b.exp[i*8 +: 8] = 8'd120;
    b.diff[0 +: 7]  = 7'h7D;
    b.diff[7 +: 7]  = 7'd40;
    b.diff[14 +: 7] = 7'h40;
    b.diff[21 +: 7] = 7'h6C;
    es = '0;
    es[0 +: SW]  = SW'(3);
    es[5 +: SW]  = SW'(31);
    es[10 +: SW] = SW'(31);
    es[15 +: SW] = SW'(20);
    drive(b, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL fp8_valid: got %b want 1", valid_out); end
    vecs++; if (sub_shift !== es) begin errs++; $display("FAIL fp8_sub_shift: got %h want %h", sub_shift, es); end
    vecs++; if (sub_sel !== 8'b0010_0001) begin errs++; $display("FAIL fp8_sub_sel: got %b want 00100001", sub_sel); end
    vecs++; if (shift_amt !== '0 || max_exp !== 8'd120) begin errs++; $display("FAIL fp8_shift: got %h max %0d want 0 max 120", shift_amt, max_exp); end
    vecs++; if (dut_o() !== model(b)) begin errs++; $display("FAIL fp8_model: got %h want %h", dut_o(), model(b)); end
    @(posedge clk); #1;
  endtask
  task automatic test_all_masked;
    beat_t b;
    b = rand_beat(8'h33);
    b.fmt = 3'd2;
    b.mask = '1;
    drive(b, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b1 || max_exp !== 8'd0) begin errs++; $display("FAIL masked_max: valid %b max %0d want 1/0", valid_out, max_exp); end
    vecs++; if (shift_amt !== '1) begin errs++; $display("FAIL masked_shift: got %h want all ones", shift_amt); end
    vecs++; if ({sub_shift, sub_sel} !== '0) begin errs++; $display("FAIL masked_sub: got %h/%h want 0", sub_shift, sub_sel); end
    vecs++; if (dut_o() !== model(b)) begin errs++; $display("FAIL masked_model: got %h want %h", dut_o(), model(b)); end
    @(posedge clk); #1;
  endtask
  task automatic test_invalid_fmt;
    beat_t bs[4];
    logic [2:0] f[4] = '{3'd0, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 4; k++) begin
      bs[k] = rand_beat(8'h40 + k);
      bs[k].fmt = f[k];
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(bs[c], 1'b1);
      else drive('0, 1'b0);
      #1;
      if (c >= 2 && c < 6) begin
        vecs++; if (valid_out !== 1'b1 || fmt_out !== f[c-2]) begin errs++; $display("FAIL invalid_fmt_pass: valid %b fmt %0d want 1/%0d", valid_out, fmt_out, f[c-2]); end
        vecs++; if ({max_exp, shift_amt, sub_shift, sub_sel} !== '0) begin errs++; $display("FAIL invalid_fmt_zero: got %h want 0", {max_exp, shift_amt, sub_shift, sub_sel}); end
        vecs++; if (dut_o() !== model(bs[c-2])) begin errs++; $display("FAIL invalid_fmt_model: got %h want %h", dut_o(), model(bs[c-2])); end
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back;
    beat_t bs[10];
    bit ev;
    for (int k = 0; k < 10; k++) bs[k] = rand_beat(k);
    ready_out = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c < 10) drive(bs[c], 1'b1);
      else drive('0, 1'b0);
      #1;
      ev = c >= 2 && c < 12;
      vecs++; if (ready_in !== 1'b1) begin errs++; $display("FAIL b2b_ready c%0d: got %b want 1", c, ready_in); end
      vecs++; if (valid_out !== ev) begin errs++; $display("FAIL b2b_valid c%0d: got %b want %b", c, valid_out, ev); end
      if (ev) begin
        vecs++; if (tag_out !== TW'(c - 2)) begin errs++; $display("FAIL b2b_tag c%0d: got %0d want %0d", c, tag_out, c - 2); end
        vecs++; if (dut_o() !== model(bs[c-2])) begin errs++; $display("FAIL b2b_model c%0d: got %h want %h", c, dut_o(), model(bs[c-2])); end
      end
      @(posedge clk); #1;
    end
  endtask
  // Elastic reference: a beat is visible once it heads the in-flight queue and is 2 cycles old.
  task automatic test_stream(input bit rnd, input int nbeats);
    out_t q[$];
    int acc[$];
    beat_t cur;
    out_t prev_o, cur_o;
    bit prev_stall, exp_rdy, exp_v, v;
    int sent, got, cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_o = '0;
    cur = rand_beat(0);
    while ((sent < nbeats || q.size() > 0) && cyc < 4000) begin
      v = sent < nbeats && (!rnd || $urandom_range(0, 9) < 7);
      drive(cur, v);
      ready_out = rnd ? ($urandom_range(0, 9) < 7) : !(cyc >= 3 && cyc < 7);
      #1;
      exp_rdy = !(q.size() == 2 && !ready_out);
      exp_v = q.size() > 0 && cyc >= acc[0] + 2;
      cur_o = dut_o();
      vecs++; if (ready_in !== exp_rdy) begin errs++; $display("FAIL stream_ready c%0d: got %b want %b", cyc, ready_in, exp_rdy); end
      vecs++; if (valid_out !== exp_v) begin errs++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, valid_out, exp_v); end
      if (exp_v) begin
        vecs++; if (cur_o !== q[0]) begin errs++; $display("FAIL stream_data c%0d: got %h want %h", cyc, cur_o, q[0]); end
      end
      if (prev_stall) begin
        vecs++; if (cur_o !== prev_o) begin errs++; $display("FAIL stream_hold c%0d: got %h want %h", cyc, cur_o, prev_o); end
      end
      prev_stall = exp_v && !ready_out;
      prev_o = cur_o;
      if (exp_v && ready_out) begin
        void'(q.pop_front());
        void'(acc.pop_front());
        got++;
      end
      if (v && exp_rdy) begin
        q.push_back(model(cur));
        acc.push_back(cyc);
        sent++;
        cur = rand_beat(sent);
      end
      @(posedge clk); #1;
      cyc++;
    end
    ready_out = 1'b1;
    drive('0, 1'b0);
    vecs++; if (got !== nbeats) begin errs++; $display("FAIL stream_count: got %0d beats want %0d", got, nbeats); end
  endtask
  task automatic test_reset_midstream;
    beat_t a, b, c;
    a = rand_beat(8'h71);
    b = rand_beat(8'h72);
    c = rand_beat(8'h73);
    ready_out = 1'b1;
    drive(a, 1'b1);
    @(posedge clk); #1;
    drive(b, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    reset = 1'b0;
    #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    vecs++; if (dut_o() !== '0) begin errs++; $display("FAIL midrst_outputs: got %h want 0", dut_o()); end
    vecs++; if (ready_in !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", ready_in); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    drive(c, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL midrst_early: got %b want 0", valid_out); end
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b1 || dut_o() !== model(c)) begin errs++; $display("FAIL midrst_new: valid %b got %h want %h", valid_out, dut_o(), model(c)); end
    @(posedge clk); #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL midrst_ghost: got %b want 0", valid_out); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    ready_out = 1'b1;
    drive('0, 1'b0);
    #2;
    test_reset;
    test_fp16;
    test_fp8;
    test_all_masked;
    test_invalid_fmt;
    test_back_to_back;
    test_stream(1'b0, 12);
    test_stream(1'b1, 300);
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
